// File: rtl/mem_access_unit_if.sv
// Requester-side handshake bundle for mem_access_unit.
// req_*: access request; rsp_*: response channel.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_mode;
  logic        req_signed;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_mode,
    output req_signed, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_mode,
    input  req_signed, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Sized load/store unit: checks alignment and drives a RAM.
// Ports: clk, clr_n, bus (slave handshake), ram_* memory side.
module mem_access_unit #(
  parameter logic [1:0] BYTE_MODE  = 2'b00,
  parameter logic [1:0] DBYTE_MODE = 2'b01,
  parameter logic [1:0] WORD_MODE  = 2'b10
) (
  input  logic                clk,
  input  logic                clr_n,
  mem_access_unit_if.slave    bus,
  output logic [11:0]         ram_addr,
  output logic [31:0]         ram_data_in,
  output logic [1:0]          ram_mode,
  output logic                ram_memwrite,
  input  logic [31:0]         ram_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t      state;
  logic        write_q;
  logic        signed_q;
  logic        bad;
  logic [31:0] ext;

  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      (bus.req_mode == 2'b11):
        bad = 1'b1;
      (bus.req_mode == DBYTE_MODE):
        bad = bus.req_addr[0];
      (bus.req_mode == WORD_MODE):
        bad = (bus.req_addr[1:0] != 2'b00);
      default:
        bad = 1'b0;
    endcase
  end

  // ram_mode holds the latched size, so it selects the extension.
  always_comb begin
    ext = ram_data_out;
    unique case (1'b1)
      (ram_mode == BYTE_MODE):
        ext = {{24{signed_q & ram_data_out[7]}},
               ram_data_out[7:0]};
      (ram_mode == DBYTE_MODE):
        ext = {{16{signed_q & ram_data_out[15]}},
               ram_data_out[15:0]};
      default:
        ext = ram_data_out;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state         <= IDLE;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= 32'd0;
      ram_memwrite  <= 1'b0;
      ram_addr      <= 12'd0;
      ram_mode      <= 2'd0;
      ram_data_in   <= 32'd0;
      write_q       <= 1'b0;
      signed_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            write_q       <= bus.req_write;
            signed_q      <= bus.req_signed;
            ram_addr      <= bus.req_addr;
            ram_mode      <= bus.req_mode;
            ram_data_in   <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            if (bad) begin
              state         <= RESP;
              bus.rsp_err   <= 1'b1;
              bus.rsp_valid <= 1'b1;
            end else begin
              state        <= ACCESS;
              bus.rsp_err  <= 1'b0;
              ram_memwrite <= bus.req_write;
            end
          end
        end
        ACCESS: begin
          state         <= RESP;
          ram_memwrite  <= 1'b0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_rdata <= write_q ? 32'd0 : ext;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          ram_memwrite  <= 1'b0;
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte RAM model.
// Checks loads, stores, errors, backpressure and reset.
module tb_mem_access_unit;
  logic        clk;
  logic        clr_n;
  logic [11:0] ram_addr;
  logic [31:0] ram_data_in;
  logic [1:0]  ram_mode;
  logic        ram_memwrite;
  logic [31:0] ram_data_out;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .bus          (bus),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_mode     (ram_mode),
    .ram_memwrite (ram_memwrite),
    .ram_data_out (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [4096];
  logic [11:0] last_wr_addr;
  logic [31:0] last_wr_data;
  int          wr_edges;

  always_comb begin
    ram_data_out = 32'd0;
    case (ram_mode)
      2'b00: ram_data_out = {24'd0, mem[ram_addr]};
      2'b01: ram_data_out = {16'd0, mem[ram_addr + 12'd1],
                             mem[ram_addr]};
      default: ram_data_out = {mem[ram_addr + 12'd3],
                               mem[ram_addr + 12'd2],
                               mem[ram_addr + 12'd1],
                               mem[ram_addr]};
    endcase
  end

  always @(posedge clk) begin
    if (ram_memwrite) begin
      wr_edges     <= wr_edges + 1;
      last_wr_addr <= ram_addr;
      last_wr_data <= ram_data_in;
      mem[ram_addr] <= ram_data_in[7:0];
      if (ram_mode != 2'b00)
        mem[ram_addr + 12'd1] <= ram_data_in[15:8];
      if (ram_mode == 2'b10) begin
        mem[ram_addr + 12'd2] <= ram_data_in[23:16];
        mem[ram_addr + 12'd3] <= ram_data_in[31:24];
      end
    end
  end

  int n_tests;
  int n_fail;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               tag, obs, exp);
    end
  endtask

  task automatic scramble();
    bus.req_addr  = 12'($urandom);
    bus.req_wdata = $urandom;
  endtask

  task automatic xfer(input logic w,
                      input logic [1:0] m,
                      input logic s,
                      input logic [11:0] a,
                      input logic [31:0] d,
                      input bit scr,
                      input bit now,
                      output logic [31:0] rd,
                      output logic er,
                      output int lat,
                      output int wc,
                      output int wt);
    wc = 0;
    wt = 0;
    lat = -1;
    if (!now) @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_mode   = m;
    bus.req_signed = s;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    while (!bus.req_ready && wt < 8) begin
      @(negedge clk);
      wt++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (scr) scramble();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ram_memwrite) wc++;
      if (bus.rsp_valid) begin
        lat = i;
        break;
      end
      if (scr) scramble();
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic [31:0] hold;
  logic        er;
  int          lat;
  int          wc;
  int          wt;
  int          wbase;

  initial begin
    n_tests = 0;
    n_fail = 0;
    wr_edges = 0;
    last_wr_addr = 12'd0;
    last_wr_data = 32'd0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_mode   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 12'd0;
    bus.req_wdata  = 32'd0;
    bus.rsp_ready  = 1'b0;
    clr_n = 1'b0;
    #12;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_memwrite", 32'(ram_memwrite), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_mode", 32'(ram_mode), 32'd0);
    chk("rst_ram_din", ram_data_in, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;

    xfer(1, 2'b10, 0, 12'h010, 32'hDEADBEEF, 0, 0,
         rd, er, lat, wc, wt);
    chk("st_w_err", 32'(er), 32'd0);
    chk("st_w_rdata", rd, 32'd0);
    chk("st_w_lat", 32'(lat), 32'd1);
    chk("st_w_wcyc", 32'(wc), 32'd1);
    xfer(0, 2'b10, 0, 12'h010, 32'h0, 0, 0,
         rd, er, lat, wc, wt);
    chk("ld_w_rdata", rd, 32'hDEADBEEF);
    chk("ld_w_err", 32'(er), 32'd0);
    chk("ld_w_wcyc", 32'(wc), 32'd0);

    xfer(1, 2'b10, 0, 12'h020, 32'h12345680, 0, 0,
         rd, er, lat, wc, wt);
    xfer(0, 2'b00, 1, 12'h020, 32'h0, 0, 0,
         rd, er, lat, wc, wt);
    chk("ld_b_s", rd, 32'hFFFFFF80);
    xfer(0, 2'b00, 0, 12'h020, 32'h0, 0, 0,
         rd, er, lat, wc, wt);
    chk("ld_b_u", rd, 32'h00000080);
    xfer(0, 2'b01, 1, 12'h022, 32'h0, 0, 0,
         rd, er, lat, wc, wt);
    chk("ld_h_s_hi", rd, 32'h00001234);
    xfer(0, 2'b01, 1, 12'h020, 32'h0, 0, 0,
         rd, er, lat, wc, wt);
    chk("ld_h_s_lo", rd, 32'h00005680);
    xfer(0, 2'b00, 1, 12'h023, 32'h0, 0, 0,
         rd, er, lat, wc, wt);
    chk("ld_b_s_pos", rd, 32'h00000012);

    xfer(1, 2'b01, 0, 12'h024, 32'hFFFF8001, 0, 0,
         rd, er, lat, wc, wt);
    xfer(0, 2'b01, 1, 12'h024, 32'h0, 0, 0,
         rd, er, lat, wc, wt);
    chk("ld_h_s_neg", rd, 32'hFFFF8001);
    xfer(0, 2'b10, 0, 12'h024, 32'h0, 0, 0,
         rd, er, lat, wc, wt);
    chk("ld_w_hstored", rd[15:0], 32'h8001);

    xfer(0, 2'b10, 0, 12'h006, 32'h0, 0, 0,
         rd, er, lat, wc, wt);
    chk("mis_w_err", 32'(er), 32'd1);
    chk("mis_w_rdata", rd, 32'd0);
    chk("mis_w_lat", 32'(lat), 32'd0);
    wbase = wr_edges;
    xfer(1, 2'b01, 0, 12'h003, 32'h0000BEEF, 0, 0,
         rd, er, lat, wc, wt);
    chk("mis_h_err", 32'(er), 32'd1);
    chk("mis_h_wcyc", 32'(wc), 32'd0);
    chk("mis_h_wedge", 32'(wr_edges - wbase), 32'd0);
    xfer(0, 2'b11, 0, 12'h000, 32'h0, 0, 0,
         rd, er, lat, wc, wt);
    chk("mode11_err", 32'(er), 32'd1);
    chk("mode11_rdata", rd, 32'd0);

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_mode  = 2'b10;
    bus.req_addr  = 12'h010;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid0", 32'(bus.rsp_valid), 32'd1);
    hold = bus.rsp_rdata;
    chk("bp_rdata0", hold, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rdata", bus.rsp_rdata, hold);
      chk("bp_rdy", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_rdy_after", 32'(bus.req_ready), 32'd1);
    chk("bp_valid_after", 32'(bus.rsp_valid), 32'd0);

    wbase = wr_edges;
    xfer(1, 2'b10, 0, 12'h040, 32'hCAFEF00D, 1, 0,
         rd, er, lat, wc, wt);
    chk("iso_wedges", 32'(wr_edges - wbase), 32'd1);
    chk("iso_waddr", 32'(last_wr_addr), 32'h040);
    chk("iso_wdata", last_wr_data, 32'hCAFEF00D);
    chk("iso_ram_addr", 32'(ram_addr), 32'h040);
    xfer(0, 2'b10, 0, 12'h040, 32'h0, 0, 0,
         rd, er, lat, wc, wt);
    chk("iso_load", rd, 32'hCAFEF00D);

    xfer(1, 2'b10, 0, 12'h030, 32'h11223344, 0, 0,
         rd, er, lat, wc, wt);
    wbase = wr_edges;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_mode  = 2'b10;
    bus.req_addr  = 12'h030;
    bus.req_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    #1;
    chk("rs_memwr_on", 32'(ram_memwrite), 32'd1);
    clr_n = 1'b0;
    #1;
    chk("rs_memwr_off", 32'(ram_memwrite), 32'd0);
    chk("rs_ready", 32'(bus.req_ready), 32'd1);
    chk("rs_addr", 32'(ram_addr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rs_no_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rs_no_write", 32'(wr_edges - wbase), 32'd0);
    clr_n = 1'b1;
    xfer(0, 2'b10, 0, 12'h030, 32'h0, 0, 1,
         rd, er, lat, wc, wt);
    chk("rs_wait", 32'(wt), 32'd0);
    chk("rs_lat", 32'(lat), 32'd1);
    chk("rs_mem", rd, 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter BYTE_MODE, default 2'b00, size code for byte access.
REQ-002 Parameter DBYTE_MODE, default 2'b01, size code for halfword access.
REQ-003 Parameter WORD_MODE, default 2'b10, size code for word access; code 2'b11 is illegal.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 clr_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  requester presents an access.
REQ-007 req_ready  output  1  unit accepts an access this cycle.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_mode  input  2  access size code.
REQ-010 req_signed  input  1  load result sign-extended when 1, zero-extended when 0.
REQ-011 req_addr  input  12  byte address.
REQ-012 req_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  requester consumes the response.
REQ-015 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-016 rsp_err  output  1  access rejected (misaligned or illegal mode).
REQ-017 ram_addr  output  12  address to memory.
REQ-018 ram_data_in  output  32  store data to memory, right-aligned.
REQ-019 ram_mode  output  2  size code to memory.
REQ-020 ram_memwrite  output  1  memory write strobe.
REQ-021 ram_data_out  input  32  combinational memory read data: byte zero-extended in [7:0], halfword in [15:0], word in full.

Function
REQ-022 The unit SHALL implement a three-state FSM: IDLE, ACCESS, RESP.
REQ-023 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-024 On acceptance, the unit SHALL latch req_write, req_mode, req_signed, req_addr and req_wdata; later changes to the req_* inputs SHALL have no effect.
REQ-025 On acceptance, a request SHALL be flagged as an error if req_mode=2'b11, or DBYTE_MODE with addr[0]=1, or WORD_MODE with addr[1:0]!=0.
REQ-026 An accepted error request SHALL move IDLE->RESP with rsp_err=1 and rsp_rdata=0, and SHALL NOT assert ram_memwrite.
REQ-027 An accepted legal request SHALL move IDLE->ACCESS, and the unit SHALL remain in ACCESS for exactly one cycle before moving to RESP.
REQ-028 ram_addr, ram_mode and ram_data_in SHALL reflect the latched request in all states after acceptance, and SHALL change only on acceptance.
REQ-029 ram_memwrite SHALL be 1 only during ACCESS of a legal store; a store therefore writes memory on exactly one clock edge.
REQ-030 At the ACCESS->RESP edge of a legal load, rsp_rdata SHALL capture ram_data_out, extended as follows:
  - byte: extend from bit 7;
  - halfword: extend from bit 15;
  - word: pass through unchanged.
  Sign-extend when req_signed=1, zero-extend when req_signed=0.
REQ-031 For a legal store, rsp_rdata SHALL be 0 and rsp_err SHALL be 0.
REQ-032 In RESP, rsp_valid SHALL be 1, and rsp_rdata/rsp_err SHALL hold stable until a rising edge with rsp_ready=1, which moves the FSM to IDLE.
REQ-033 rsp_valid SHALL be 0 outside RESP; minimum spacing between accepted requests is 3 cycles (2 for error requests).
REQ-034 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-035 While clr_n=0, and immediately on its falling edge independent of clk, the unit SHALL force:
  - FSM to IDLE;
  - req_ready=1;
  - rsp_valid=0, rsp_err=0, rsp_rdata=0;
  - ram_memwrite=0, ram_addr=0, ram_mode=0, ram_data_in=0.
REQ-036 A reset asserted during ACCESS SHALL abort the access with no memory write and no response; after reset release the unit SHALL accept a new request on the first rising edge.

Verification
REQ-037 Word store then load: store addr 0x010, data 0xDEADBEEF; load addr 0x010 word -> ram_memwrite high for exactly 1 cycle; load rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-038 Signed/unsigned byte load: memory word at 0x020 = 0x12345680; byte load addr 0x020 signed -> 0xFFFFFF80; unsigned -> 0x00000080; halfword addr 0x022 signed -> 0x00001234.
REQ-039 Misaligned requests: word load addr 0x006 -> rsp_err=1, rsp_rdata=0, no ACCESS state; halfword store addr 0x003 -> rsp_err=1, ram_memwrite never 1; mode 2'b11 -> rsp_err=1.
REQ-040 Backpressure: hold rsp_ready=0 for 5 cycles after a load -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; then rsp_ready=1 -> req_ready=1 on the next cycle.
REQ-041 Reset mid-store: assert clr_n=0 during ACCESS of a word store to 0x030 (data 0xA5A5A5A5) -> ram_memwrite drops asynchronously, memory at 0x030 unchanged, no rsp_valid; after release, a new request is accepted immediately.
REQ-042 Input isolation: change req_addr/req_wdata every cycle after acceptance -> memory sees only the latched values.
